scmp_microcode_seq: RTL and testbench

//  Microprogram sequencer for the SC/MP core: holds the microcode PC, executes per-microword next-address control
//  (seq/jump/branch/call/return/dispatch) and maps opcodes to microcode entry points through a programmable

---
 rtl/scmp_microcode_seq_pkg.sv | 52 +++++
 rtl/scmp_microcode_seq_dispatch.sv | 28 ++
 rtl/scmp_microcode_seq.sv | 186 ++++++++++++++++++
 tb/tb_scmp_microcode_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scmp_microcode_seq_pkg.sv
// Shared types and constants for the SC/MP microprogram sequencer.
package scmp_microcode_seq_pkg;

    // Microcode entry-point labels used as dispatch targets.
    localparam logic [5:0] UCLBL_FETCH = 6'h04;
    localparam logic [5:0] UCLBL_LD    = 6'h08;
    localparam logic [5:0] UCLBL_ST    = 6'h0C;
    localparam logic [5:0] UCLBL_ILD   = 6'h10;
    localparam logic [5:0] UCLBL_DLD   = 6'h14;
    localparam logic [5:0] UCLBL_JMP   = 6'h18;

    // Next-address control field of a microword; codes 6 and 7 are reserved.
    typedef enum logic [2:0] {
        SEQ  = 3'd0,
        JMP  = 3'd1,
        BRC  = 3'd2,
        CALL = 3'd3,
        RET  = 3'd4,
        DISP = 3'd5
    } useq_ctl_t;

    typedef struct packed {
        logic       en;
        logic [7:0] mask;
        logic [7:0] match;
        logic [5:0] tgt;
    } disp_rule_t;

    localparam int unsigned DISP_RESET_N = 8;

    localparam disp_rule_t DISP_RESET_TBL [DISP_RESET_N] = '{
        '{1'b1, 8'hFF, 8'hCC, UCLBL_FETCH},
        '{1'b1, 8'hF8, 8'hC8, UCLBL_ST},
        '{1'b1, 8'hF8, 8'hC0, UCLBL_LD},
        '{1'b1, 8'hFC, 8'hA8, UCLBL_ILD},
        '{1'b1, 8'hFC, 8'hB8, UCLBL_DLD},
        '{1'b1, 8'hF0, 8'h90, UCLBL_JMP},
        '{1'b0, 8'h00, 8'h00, 6'h00},
        '{1'b0, 8'h00, 8'h00, 6'h00}
    };

    // Reset-table entry for any rule index; indices beyond the table are disabled.
    function automatic disp_rule_t reset_rule(input int unsigned idx);
        disp_rule_t r;
        r = '0;
        if (idx < DISP_RESET_N) begin
            r = DISP_RESET_TBL[idx[2:0]];
        end
        return r;
    endfunction

endpackage

// File: rtl/scmp_microcode_seq_dispatch.sv
// Combinational opcode -> microcode entry point matcher; lowest enabled matching rule wins.
module scmp_microcode_dispatch
    import scmp_microcode_seq_pkg::*;
#(
    parameter int unsigned      OP_W       = 8,
    parameter int unsigned      UPC_W      = 6,
    parameter int unsigned      NUM_RULES  = 8,
    parameter logic [UPC_W-1:0] DEFAULT_PC = '0
) (
    input  logic [NUM_RULES-1:0]            i_rule_en,
    input  logic [NUM_RULES-1:0][OP_W-1:0]  i_rule_mask,
    input  logic [NUM_RULES-1:0][OP_W-1:0]  i_rule_match,
    input  logic [NUM_RULES-1:0][UPC_W-1:0] i_rule_tgt,
    input  logic [OP_W-1:0]                 i_op,
    output logic [UPC_W-1:0]                o_tgt
);

    // Scan high to low so the lowest-index hit is the last assignment.
    always_comb begin
        o_tgt = DEFAULT_PC;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (i_rule_en[i] && ((i_op & i_rule_mask[i]) == i_rule_match[i])) begin
                o_tgt = i_rule_tgt[i];
            end
        end
    end

endmodule

// File: rtl/scmp_microcode_seq.sv
// Microprogram sequencer: microcode PC, call stack, opcode register and dispatch table.
module scmp_microcode_seq
    import scmp_microcode_seq_pkg::*;
#(
    parameter int unsigned      OP_W        = 8,
    parameter int unsigned      UPC_W       = 6,
    parameter int unsigned      NUM_RULES   = 8,
    parameter int unsigned      STACK_DEPTH = 4,
    parameter logic [UPC_W-1:0] RESET_PC    = '0,
    parameter logic [UPC_W-1:0] DEFAULT_PC  = UPC_W'(UCLBL_FETCH),
    localparam int unsigned     IDX_W       = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [OP_W-1:0]  op_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [2:0]       ctl_i,
    input  logic [UPC_W-1:0] tgt_i,
    input  logic             cond_i,
    output logic [UPC_W-1:0] upc_o,
    output logic             stall_o,
    output logic             err_ovf_o,
    output logic             err_unf_o,
    input  logic             err_clr_i,
    input  logic             cfg_we_i,
    input  logic [IDX_W-1:0] cfg_idx_i,
    input  logic             cfg_en_i,
    input  logic [OP_W-1:0]  cfg_mask_i,
    input  logic [OP_W-1:0]  cfg_match_i,
    input  logic [UPC_W-1:0] cfg_tgt_i
);

    // Stack array is padded to a power of two so the pointer indexes it exactly.
    localparam int unsigned SP_W        = $clog2(STACK_DEPTH + 1);
    localparam int unsigned STK_N       = 1 << SP_W;
    localparam bit          USE_RST_TBL = (OP_W == 8) && (NUM_RULES >= 6);

    logic [UPC_W-1:0]               r_upc;
    logic [UPC_W-1:0]               r_stk [STK_N];
    logic [SP_W-1:0]                r_sp;
    logic [OP_W-1:0]                r_op;
    logic                           r_op_full;
    logic                           r_ovf;
    logic                           r_unf;
    logic [NUM_RULES-1:0]           r_rule_en;
    logic [NUM_RULES-1:0][OP_W-1:0] r_rule_mask;
    logic [NUM_RULES-1:0][OP_W-1:0] r_rule_match;
    logic [NUM_RULES-1:0][UPC_W-1:0] r_rule_tgt;

    logic [UPC_W-1:0] w_upc_d;
    logic [UPC_W-1:0] w_upc_inc;
    logic [UPC_W-1:0] w_disp_tgt;
    logic [SP_W-1:0]  w_sp_top;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_consume;
    logic             w_cfg_ok;
    disp_rule_t       w_rst_rule [NUM_RULES];

    for (genvar g = 0; g < NUM_RULES; g++) begin : g_rst_rule
        assign w_rst_rule[g] = reset_rule(g);
    end

    assign w_upc_inc  = r_upc + UPC_W'(1);
    assign w_sp_top   = r_sp - SP_W'(1);
    assign w_cfg_ok   = (32'(cfg_idx_i) < NUM_RULES);
    assign upc_o      = r_upc;
    assign op_ready_o = !r_op_full;
    assign err_ovf_o  = r_ovf;
    assign err_unf_o  = r_unf;

    scmp_microcode_dispatch #(
        .OP_W       (OP_W),
        .UPC_W      (UPC_W),
        .NUM_RULES  (NUM_RULES),
        .DEFAULT_PC (DEFAULT_PC)
    ) u_dispatch (
        .i_rule_en    (r_rule_en),
        .i_rule_mask  (r_rule_mask),
        .i_rule_match (r_rule_match),
        .i_rule_tgt   (r_rule_tgt),
        .i_op         (r_op),
        .o_tgt        (w_disp_tgt)
    );

    // Next microcode address and stack/error side effects of the current microword.
    always_comb begin
        w_upc_d   = r_upc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        w_consume = 1'b0;
        stall_o   = 1'b0;
        if (ce) begin
            case (useq_ctl_t'(ctl_i))
                SEQ: w_upc_d = w_upc_inc;
                JMP: w_upc_d = tgt_i;
                BRC: w_upc_d = cond_i ? tgt_i : w_upc_inc;
                CALL: begin
                    w_upc_d = tgt_i;
                    if (r_sp == SP_W'(STACK_DEPTH)) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                RET: begin
                    if (r_sp == '0) begin
                        w_upc_d   = RESET_PC;
                        w_unf_set = 1'b1;
                    end else begin
                        w_upc_d = r_stk[w_sp_top];
                        w_pop   = 1'b1;
                    end
                end
                DISP: begin
                    if (r_op_full) begin
                        w_upc_d   = w_disp_tgt;
                        w_consume = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
                default: w_upc_d = w_upc_inc;
            endcase
        end
    end

    // State update: PC, stack, opcode register, sticky errors and dispatch table.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_upc     <= RESET_PC;
            r_sp      <= '0;
            r_op      <= '0;
            r_op_full <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            for (int i = 0; i < STK_N; i++) begin
                r_stk[i] <= '0;
            end
            for (int i = 0; i < NUM_RULES; i++) begin
                r_rule_en[i]    <= USE_RST_TBL && w_rst_rule[i].en;
                r_rule_mask[i]  <= USE_RST_TBL ? OP_W'(w_rst_rule[i].mask) : '0;
                r_rule_match[i] <= USE_RST_TBL ? OP_W'(w_rst_rule[i].match) : '0;
                r_rule_tgt[i]   <= USE_RST_TBL ? UPC_W'(w_rst_rule[i].tgt) : '0;
            end
        end else begin
            r_upc <= w_upc_d;
            if (w_push) begin
                r_stk[r_sp] <= w_upc_inc;
                r_sp        <= r_sp + SP_W'(1);
            end else if (w_pop) begin
                r_sp <= w_sp_top;
            end
            // Ready is registered, so a load can never coincide with a consume.
            if (op_valid_i && !r_op_full) begin
                r_op      <= op_i;
                r_op_full <= 1'b1;
            end else if (w_consume) begin
                r_op_full <= 1'b0;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (ce && err_clr_i) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (ce && err_clr_i) begin
                r_unf <= 1'b0;
            end
            if (cfg_we_i && w_cfg_ok) begin
                r_rule_en[cfg_idx_i]    <= cfg_en_i;
                r_rule_mask[cfg_idx_i]  <= cfg_mask_i;
                r_rule_match[cfg_idx_i] <= cfg_match_i;
                r_rule_tgt[cfg_idx_i]   <= cfg_tgt_i;
            end
        end
    end

endmodule

// File: tb/tb_scmp_microcode_seq.sv
// Scoreboard bench for scmp_microcode_seq: driver pushes model expectations, monitor compares.
module tb_scmp_microcode_seq;
    import scmp_microcode_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, ce, op_valid_i, op_ready_o, cond_i, stall_o;
    logic [7:0] op_i, cfg_mask_i, cfg_match_i;
    logic [2:0] ctl_i, cfg_idx_i;
    logic [5:0] tgt_i, upc_o, cfg_tgt_i;
    logic       err_ovf_o, err_unf_o, err_clr_i, cfg_we_i, cfg_en_i;

    always #5 clk = ~clk;

    scmp_microcode_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .op_i        (op_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready_o),
        .ctl_i       (ctl_i),
        .tgt_i       (tgt_i),
        .cond_i      (cond_i),
        .upc_o       (upc_o),
        .stall_o     (stall_o),
        .err_ovf_o   (err_ovf_o),
        .err_unf_o   (err_unf_o),
        .err_clr_i   (err_clr_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_idx_i   (cfg_idx_i),
        .cfg_en_i    (cfg_en_i),
        .cfg_mask_i  (cfg_mask_i),
        .cfg_match_i (cfg_match_i),
        .cfg_tgt_i   (cfg_tgt_i)
    );

    typedef struct {
        bit stall;
        int upc;
        bit ovf;
        bit unf;
        bit rdy;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: plain integers, a list for the call stack, arrays for the table.
    int   m_upc;
    int   m_stk[$];
    bit   m_held, m_ovf, m_unf;
    int   m_op;
    bit   m_en[8];
    int   m_mask[8], m_match[8], m_tgt[8];

    function automatic int lookup(input int op);
        for (int r = 0; r < 8; r++) begin
            if (m_en[r] && ((op & m_mask[r]) == m_match[r])) return m_tgt[r];
        end
        return int'(UCLBL_FETCH);
    endfunction

    function automatic void model_reset();
        int rm[6] = '{'hFF, 'hF8, 'hF8, 'hFC, 'hFC, 'hF0};
        int rc[6] = '{'hCC, 'hC8, 'hC0, 'hA8, 'hB8, 'h90};
        int rt[6];
        rt = '{int'(UCLBL_FETCH), int'(UCLBL_ST), int'(UCLBL_LD), int'(UCLBL_ILD),
               int'(UCLBL_DLD), int'(UCLBL_JMP)};
        m_upc = 0; m_stk.delete(); m_held = 0; m_ovf = 0; m_unf = 0;
        for (int r = 0; r < 8; r++) begin
            m_en[r]    = (r < 6);
            m_mask[r]  = (r < 6) ? rm[r] : 0;
            m_match[r] = (r < 6) ? rc[r] : 0;
            m_tgt[r]   = (r < 6) ? rt[r] : 0;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock with the inputs currently driven; push the model's prediction.
    task automatic cyc();
        exp_t e;
        bit   pre_ready, ovf_set, unf_set;
        e.stall = ce && (ctl_i == 3'd5) && !m_held;
        if (!rst_n) begin
            model_reset();
        end else begin
            pre_ready = !m_held;
            ovf_set   = 0;
            unf_set   = 0;
            if (ce) begin
                case (int'(ctl_i))
                    1: m_upc = tgt_i;
                    2: m_upc = cond_i ? int'(tgt_i) : (m_upc + 1) % 64;
                    3: begin
                        if (m_stk.size() < 4) m_stk.push_back((m_upc + 1) % 64);
                        else ovf_set = 1;
                        m_upc = tgt_i;
                    end
                    4: begin
                        if (m_stk.size() == 0) begin
                            m_upc = 0;
                            unf_set = 1;
                        end else begin
                            m_upc = m_stk.pop_back();
                        end
                    end
                    5: if (m_held) begin
                        m_upc = lookup(m_op);
                        m_held = 0;
                    end
                    default: m_upc = (m_upc + 1) % 64;
                endcase
            end
            m_ovf = ovf_set || (m_ovf && !(ce && err_clr_i));
            m_unf = unf_set || (m_unf && !(ce && err_clr_i));
            if (op_valid_i && pre_ready) begin
                m_held = 1;
                m_op   = op_i;
            end
            if (cfg_we_i) begin
                m_en[cfg_idx_i]    = cfg_en_i;
                m_mask[cfg_idx_i]  = cfg_mask_i;
                m_match[cfg_idx_i] = cfg_match_i;
                m_tgt[cfg_idx_i]   = cfg_tgt_i;
            end
        end
        e.upc = m_upc; e.ovf = m_ovf; e.unf = m_unf; e.rdy = !m_held;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic defaults();
        rst_n = 1; ce = 1; ctl_i = 3'd0; tgt_i = '0; cond_i = 0; op_valid_i = 0; op_i = '0;
        err_clr_i = 0; cfg_we_i = 0; cfg_idx_i = '0; cfg_en_i = 0; cfg_mask_i = '0;
        cfg_match_i = '0; cfg_tgt_i = '0;
    endtask

    task automatic go(input logic [2:0] c, input logic [5:0] t);
        ctl_i = c;
        tgt_i = t;
        cyc();
        defaults();
    endtask

    task automatic load_op(input logic [7:0] op);
        op_valid_i = 1;
        op_i = op;
        go(3'd0, 6'd0);
    endtask

    // Monitor: stall is combinational on this cycle's inputs; state is checked after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q[0];
                chk("stall_o", int'(stall_o), int'(e.stall));
                @(posedge clk);
                #1;
                e = q.pop_front();
                chk("upc_o", int'(upc_o), e.upc);
                chk("err_ovf_o", int'(err_ovf_o), int'(e.ovf));
                chk("err_unf_o", int'(err_unf_o), int'(e.unf));
                chk("op_ready_o", int'(op_ready_o), int'(e.rdy));
            end
        end
    end

    initial begin
        model_reset();
        defaults();
        rst_n = 0;
        @(negedge clk);
        // Reset and first dispatch of C3.
        rst_n = 0; cyc(); rst_n = 0; cyc(); defaults();
        load_op(8'hC3);
        go(3'd5, 6'd0);
        // Table lookups including the no-hit default.
        load_op(8'hCC); go(3'd5, 6'd0);
        load_op(8'hCD); go(3'd5, 6'd0);
        load_op(8'h07); go(3'd5, 6'd0);
        // Stall while no opcode is held, then an opcode arrives.
        go(3'd5, 6'd0); go(3'd5, 6'd0); go(3'd5, 6'd0);
        op_valid_i = 1; op_i = 8'h94; go(3'd5, 6'd0);
        go(3'd5, 6'd0);
        // Call-stack overflow and underflow, then clear.
        go(3'd1, 6'h01);
        go(3'd3, 6'h10); go(3'd3, 6'h20); go(3'd3, 6'h30); go(3'd3, 6'h38); go(3'd3, 6'h3C);
        for (int i = 0; i < 5; i++) go(3'd4, 6'd0);
        err_clr_i = 1; go(3'd0, 6'd0);
        // Table write racing a dispatch uses the old table.
        load_op(8'h05);
        cfg_we_i = 1; cfg_idx_i = 3'd6; cfg_en_i = 1; cfg_mask_i = 8'hF0;
        cfg_match_i = 8'h00; cfg_tgt_i = 6'h2A;
        go(3'd5, 6'd0);
        load_op(8'h05); go(3'd5, 6'd0);
        // PC wrap, ce hold, reset mid-call.
        go(3'd1, 6'h3F); go(3'd0, 6'd0);
        ce = 0; go(3'd1, 6'h15);
        go(3'd2, 6'h22); cond_i = 1; go(3'd2, 6'h22);
        go(3'd3, 6'h05);
        rst_n = 0; go(3'd0, 6'd0);
        go(3'd4, 6'd0);
        go(3'd6, 6'h11); go(3'd7, 6'h11);
        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            ce         = ($urandom_range(0, 3) != 0);
            ctl_i      = 3'($urandom_range(0, 7));
            tgt_i      = 6'($urandom);
            cond_i     = 1'($urandom);
            op_valid_i = 1'($urandom);
            op_i       = 8'($urandom);
            err_clr_i  = ($urandom_range(0, 15) == 0);
            cfg_we_i   = ($urandom_range(0, 15) == 0);
            cfg_idx_i  = 3'($urandom);
            cfg_en_i   = 1'($urandom);
            cfg_mask_i = 8'($urandom);
            cfg_match_i = 8'($urandom) & cfg_mask_i;
            cfg_tgt_i  = 6'($urandom);
            cyc();
        end
        defaults();
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
